// File: rtl/irrigation_timer_controller_pkg.sv
// Shared definitions for the irrigation countdown timer: state encoding,
// BCD digit limits and digit widths.
package irrigation_timer_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam int UNITS_MAX = 9;
    localparam int TENS_MAX  = 5;
    localparam int TENS_W    = 3;
    localparam int UNITS_W   = 4;
    localparam int PRESC_W   = 8;

endpackage

// File: rtl/irrigation_timer_controller_timer_digit.sv
// One BCD digit down-counter; wraps 0 -> MAX and reports a borrow to the
// next more significant digit when it does.
module timer_digit #(
    parameter int W   = 4,
    parameter int MAX = 9
) (
    input  logic         clock_i,
    input  logic         reset_n_i,
    input  logic         load_i,
    input  logic [W-1:0] load_value_i,
    input  logic         dec_en_i,
    input  logic         clear_i,
    output logic [W-1:0] q_o,
    output logic         is_zero_o,
    output logic         borrow_out_o
);

    localparam logic [W-1:0] MAX_V = W'(MAX);
    localparam logic [W-1:0] ONE_V = W'(1);

    logic [W-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (clear_i)
            q_d = '0;
        else if (load_i)
            q_d = load_value_i;
        else if (dec_en_i)
            q_d = is_zero_o ? MAX_V : q_q - ONE_V;
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i)
            q_q <= '0;
        else
            q_q <= q_d;
    end

    assign q_o          = q_q;
    assign is_zero_o    = (q_q == '0);
    assign borrow_out_o = dec_en_i & is_zero_o;

endmodule

// File: rtl/irrigation_timer_controller.sv
// Irrigation countdown sequencer: preset load/validation, tick prescaler,
// MM:SS borrow chain and the IDLE/RUN/PAUSE/DONE control FSM.
module irrigation_timer_controller
    import irrigation_timer_controller_pkg::*;
#(
    parameter int TICK_DIV = 1,
    parameter int TENS_MAX = 5
) (
    input  logic               clock_i,
    input  logic               reset_n_i,
    input  logic               tick_i,
    input  logic               start_i,
    input  logic               pause_i,
    input  logic               abort_i,
    input  logic [TENS_W-1:0]  preset_min_tens_i,
    input  logic [UNITS_W-1:0] preset_min_units_i,
    input  logic [TENS_W-1:0]  preset_sec_tens_i,
    input  logic [UNITS_W-1:0] preset_sec_units_i,
    output logic [TENS_W-1:0]  min_tens_o,
    output logic [UNITS_W-1:0] min_units_o,
    output logic [TENS_W-1:0]  sec_tens_o,
    output logic [UNITS_W-1:0] sec_units_o,
    output logic [1:0]         state_o,
    output logic               valve_o,
    output logic               done_o,
    output logic               preset_err_o
);

    localparam logic [TENS_W-1:0]  TENS_MAX_V  = TENS_W'(TENS_MAX);
    localparam logic [UNITS_W-1:0] UNITS_MAX_V = UNITS_W'(UNITS_MAX);
    localparam logic [UNITS_W-1:0] UNITS_ONE_V = UNITS_W'(1);
    localparam logic [PRESC_W-1:0] PRESC_LAST  = PRESC_W'(TICK_DIV - 1);
    localparam logic [PRESC_W-1:0] PRESC_ONE   = PRESC_W'(1);

    state_t             state_q, state_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               err_q, err_d;
    logic               load, clear, dec;

    logic mt_zero, mu_zero, st_zero, su_zero;
    logic su_borrow, st_borrow, mu_borrow, mt_borrow;

    logic preset_ok, preset_zero, last_sec;

    assign preset_ok = (preset_min_tens_i  <= TENS_MAX_V)  && (preset_min_units_i <= UNITS_MAX_V) &&
                       (preset_sec_tens_i  <= TENS_MAX_V)  && (preset_sec_units_i <= UNITS_MAX_V);
    assign preset_zero = (preset_min_tens_i == '0) && (preset_min_units_i == '0) &&
                         (preset_sec_tens_i == '0) && (preset_sec_units_i == '0);
    // The decrement that lands on 00:00 is the one taken from 00:01.
    assign last_sec = mt_zero && mu_zero && st_zero && (sec_units_o == UNITS_ONE_V);

    timer_digit #(.W(UNITS_W), .MAX(UNITS_MAX)) u_sec_units (
        .clock_i(clock_i), .reset_n_i(reset_n_i), .load_i(load), .load_value_i(preset_sec_units_i),
        .dec_en_i(dec), .clear_i(clear), .q_o(sec_units_o), .is_zero_o(su_zero), .borrow_out_o(su_borrow));

    timer_digit #(.W(TENS_W), .MAX(TENS_MAX)) u_sec_tens (
        .clock_i(clock_i), .reset_n_i(reset_n_i), .load_i(load), .load_value_i(preset_sec_tens_i),
        .dec_en_i(su_borrow), .clear_i(clear), .q_o(sec_tens_o), .is_zero_o(st_zero), .borrow_out_o(st_borrow));

    timer_digit #(.W(UNITS_W), .MAX(UNITS_MAX)) u_min_units (
        .clock_i(clock_i), .reset_n_i(reset_n_i), .load_i(load), .load_value_i(preset_min_units_i),
        .dec_en_i(st_borrow), .clear_i(clear), .q_o(min_units_o), .is_zero_o(mu_zero), .borrow_out_o(mu_borrow));

    timer_digit #(.W(TENS_W), .MAX(TENS_MAX)) u_min_tens (
        .clock_i(clock_i), .reset_n_i(reset_n_i), .load_i(load), .load_value_i(preset_min_tens_i),
        .dec_en_i(mu_borrow), .clear_i(clear), .q_o(min_tens_o), .is_zero_o(mt_zero), .borrow_out_o(mt_borrow));

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ST_IDLE;
            presc_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        err_d   = 1'b0;
        load    = 1'b0;
        clear   = 1'b0;
        dec     = 1'b0;
        if (abort_i) begin
            state_d = ST_IDLE;
            presc_d = '0;
            clear   = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        if (preset_ok) begin
                            load    = 1'b1;
                            presc_d = '0;
                            state_d = preset_zero ? ST_DONE : ST_RUN;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (pause_i) begin
                        state_d = ST_PAUSE;
                    end else if (tick_i) begin
                        if (presc_q == PRESC_LAST) begin
                            presc_d = '0;
                            dec     = 1'b1;
                            if (last_sec)
                                state_d = ST_DONE;
                        end else begin
                            presc_d = presc_q + PRESC_ONE;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (start_i)
                        state_d = ST_RUN;
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        valve_o = (state_q == ST_RUN);
        done_o  = (state_q == ST_DONE);
    end

    assign state_o      = state_q;
    assign preset_err_o = err_q;

endmodule

// File: doc/irrigation_timer_controller.md
Name: irrigation_timer_controller

Overview:
Sequencer for the irrigation countdown timer. Owns the MM:SS BCD countdown chain, which is built from four digit down-counters (two 0–9 units digits, two 0–5 tens digits). It loads a preset, starts, pauses, resumes and aborts the countdown. It also drives the valve enable and signals completion. It sits between the front-panel/command logic and the valve driver and display.

Parameters:
TICK_DIV, 1, number of tick pulses per one-second decrement (legal range 1..255)
TENS_MAX, 5, terminal value of both tens digits (fixed for MM:SS; exposed for test)

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-low; clears all state
tick  input  1  single-cycle time-base pulse
start  input  1  load-and-run in IDLE; resume in PAUSE
pause  input  1  freeze countdown while RUN
abort  input  1  return to IDLE from any state, digits cleared
preset_min_tens  input  3  BCD 0..5
preset_min_units  input  4  BCD 0..9
preset_sec_tens  input  3  BCD 0..5
preset_sec_units  input  4  BCD 0..9
min_tens  output  3  current digit
min_units  output  4  current digit
sec_tens  output  3  current digit
sec_units  output  4  current digit
state  output  2  IDLE=00, RUN=01, PAUSE=10, DONE=11
valve  output  1  high exactly while state==RUN
done  output  1  one-cycle pulse on reaching 00:00
preset_err  output  1  one-cycle pulse when start rejects an invalid preset

Behaviour:
- Reset (async, active-low): state=IDLE, all digits 0, valve=0, done=0, preset_err=0, tick prescaler=0.
- Command priority within one cycle: abort > pause > start > tick.
- IDLE:
  - On start with a valid preset, all four digits load on the next edge.
  - If the preset is nonzero, go to RUN. If the preset is 00:00, go to DONE.
  - An invalid preset (any units >9 or tens >TENS_MAX) leaves state and digits unchanged and pulses preset_err for 1 cycle.
  - A tick coinciding with start is ignored.
- RUN:
  - Each tick increments the prescaler. When the prescaler reaches TICK_DIV-1 and a tick arrives, the prescaler wraps to 0 and the count decrements by one second.
  - Decrement is a borrow chain. sec_units 0→9 borrows from sec_tens. sec_tens 0→TENS_MAX borrows from min_units. min_units 0→9 borrows from min_tens.
  - A decrement taking 00:01 to 00:00 moves to DONE on the same edge and asserts done for that cycle. The count never wraps past 00:00.
- RUN + pause: go to PAUSE; a coincident tick is dropped. The prescaler holds its value.
- PAUSE: digits and prescaler frozen; ticks ignored. start → RUN (no reload); a coincident tick is ignored.
- DONE: lasts exactly one cycle, then goes to IDLE. Digits hold 00:00 in IDLE until the next load.
- abort in any state: IDLE on the next edge, digits cleared to 0, prescaler cleared, no done pulse. abort in the same cycle as the final decrement takes priority, so no done pulse.
- pause or start in states where they are undefined above is ignored. start in RUN does not reload.
- valve is decoded from registered state only (glitch-free), so it has zero latency relative to state.

Decomposition:
- Shared package holds:
  - state encoding constants IDLE/RUN/PAUSE/DONE
  - BCD limits UNITS_MAX=9 and TENS_MAX=5
  - digit widths (3 for tens, 4 for units)
- One sub-module, timer_digit, is instantiated 4×. Parameters: MAX and width. Inputs: load, load_value, dec_en, clear. Outputs: q, is_zero, borrow_out (= dec_en & is_zero).
- The controller FSM, prescaler, preset validation and zero detection stay in irrigation_timer_controller.

Test Plan:
1. Reset mid-RUN at 01:23 → all outputs 0 and state=IDLE asynchronously, before the next clock edge.
2. Preset 00:03, start, 3 ticks (TICK_DIV=1) → digits step 00:02, 00:01, 00:00. done pulses once on the third tick edge, valve falls that same edge, state reads DONE for 1 cycle then IDLE.
3. Preset 10:00, start, 1 tick → 09:59 (full borrow chain). Then pause together with a tick → count stays 09:59. start → RUN, and subsequent ticks continue from 09:59.
4. Preset sec_units=10 or sec_tens=6, start → preset_err pulses 1 cycle, state stays IDLE, digits unchanged. Preset 00:00, start → DONE, done pulse, valve never asserts.
5. TICK_DIV=3, preset 00:02: 6 ticks needed for done. pause after tick 2, resume, then one more tick → decrement to 00:01 (prescaler preserved).
6. abort coincident with the final tick at 00:01 → state=IDLE, digits 00:00, no done pulse. abort in PAUSE → IDLE, digits cleared.
